uart_fpga_top_rx: RTL and testbench

- UART serial receiver for the FPGA top: 8N1 frame, LSB first, one system clock.
- Feeds the received-data holding register: `rx_data` drives the mux's `in1`, and `rx_done` drives its `sel` for exactly one cycle per good frame.
- Detects start-bit glitches and framing errors, and reports a busy status.

---
 rtl/uart_fpga_top_rx.sv | 157 +++++++++++++++
 tb/tb_uart_fpga_top_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fpga_top_rx.sv
// uart_fpga_top_rx: 8N1 UART receiver with 2-flop input synchroniser and one-cycle done/error pulses.
// Define UART_RX_PARITY_EN to insert an even-parity bit and the parity_error output.
module uart_fpga_top_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       framing_error,
`ifdef UART_RX_PARITY_EN
    output logic       parity_error,
`endif
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_rx_d;
    logic [CW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_rx_data;
    logic            r_rx_done;
    logic            r_framing_error;
    logic            r_busy;
`ifdef UART_RX_PARITY_EN
    logic            r_parity_error;
    logic            r_par_bad;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1         <= 1'b1;
            r_sync2         <= 1'b1;
            r_rx_d          <= 1'b1;
            r_state         <= S_IDLE;
            r_baud_cnt      <= '0;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_rx_data       <= '0;
            r_rx_done       <= 1'b0;
            r_framing_error <= 1'b0;
            r_busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_error  <= 1'b0;
            r_par_bad       <= 1'b0;
`endif
        end else begin
            r_sync1         <= rx;
            r_sync2         <= r_sync1;
            r_rx_d          <= r_sync2;
            r_rx_done       <= 1'b0;
            r_framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_error  <= 1'b0;
`endif
            r_baud_cnt      <= r_baud_cnt + 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    // Only a fresh 1->0 transition starts a frame; a held-low line does not.
                    if (r_rx_d && !r_sync2) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_baud_cnt == HALF_M1) begin
                        r_baud_cnt <= '0;
                        if (!r_sync2) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    if (r_baud_cnt == FULL_M1) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {r_sync2, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_baud_cnt == FULL_M1) begin
                        r_baud_cnt <= '0;
                        r_par_bad  <= r_sync2 ^ (^r_shift);
                        r_state    <= S_STOP;
                    end
                end
`endif

                S_STOP: begin
                    // Returning to IDLE at the stop-bit centre leaves half a bit to catch the next start edge.
                    if (r_baud_cnt == FULL_M1) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        if (!r_sync2) begin
                            r_framing_error <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (r_par_bad) begin
                            r_parity_error <= 1'b1;
`endif
                        end else begin
                            r_rx_data <= r_shift;
                            r_rx_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_baud_cnt <= '0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_done       = r_rx_done;
    assign framing_error = r_framing_error;
    assign busy          = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = r_parity_error;
`endif

endmodule

// File: tb/tb_uart_fpga_top_rx.sv
// Testbench for uart_fpga_top_rx: directed and random frames checked against a frame-level model.
// Parity scenarios run when UART_RX_PARITY_EN is defined.
module tb_uart_fpga_top_rx;

    localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_BITS = PAR_EN ? 11 : 10;
    // rx_done is expected roughly 9.5 bit times (10.5 with parity) plus synchroniser delay after the fall
    localparam int LAT_LO = (FRAME_BITS - 1) * CPB + CPB / 2 + 1;
    localparam int LAT_HI = (FRAME_BITS - 1) * CPB + CPB / 2 + 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       framing_error;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
    int         mon_pe = 0;
    int         b_pe;
`endif

    uart_fpga_top_rx #(
        .CLK_FREQ (1000000),
        .BAUD     (100000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .framing_error (framing_error),
`ifdef UART_RX_PARITY_EN
        .parity_error  (parity_error),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         n_vec = 0;
    int         n_miss = 0;
    logic [7:0] mon_done_data[$];
    int         mon_done_cyc[$];
    int         mon_fe = 0;
    int         mon_overlap = 0;
    int         b_done;
    int         b_fe;
    int         t_fall;
    logic [7:0] exp_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            mon_done_data.push_back(rx_data);
            mon_done_cyc.push_back(cyc);
        end
        if (framing_error === 1'b1) mon_fe++;
        if (rx_done === 1'b1 && framing_error === 1'b1) mon_overlap++;
`ifdef UART_RX_PARITY_EN
        if (parity_error === 1'b1) mon_pe++;
        if (parity_error === 1'b1 && (rx_done === 1'b1 || framing_error === 1'b1)) mon_overlap++;
`endif
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_done = mon_done_data.size();
        b_fe   = mon_fe;
`ifdef UART_RX_PARITY_EN
        b_pe   = mon_pe;
`endif
    endtask

    // Send one frame and check its outcome from the frame rules: good only with stop=1 and correct parity
    task automatic frame(input string name, input logic [7:0] d, input logic stop_bit, input logic par_flip);
        logic bits[$];
        logic good;
        int   lat;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PAR_EN) bits.push_back((^d) ^ par_flip);
        bits.push_back(stop_bit);
        good = stop_bit && !(PAR_EN && par_flip);
        snap();
        t_fall = cyc;
        foreach (bits[i]) begin
            rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        if (good) exp_data = d;
        chk({name, ":done_count"}, mon_done_data.size() - b_done, {31'd0, good});
        if (mon_done_data.size() > b_done) begin
            chk({name, ":done_data"}, {24'd0, mon_done_data[b_done]}, {24'd0, d});
            lat = mon_done_cyc[b_done] - t_fall;
            chk($sformatf("%s:latency_in_window(lat=%0d)", name, lat),
                {31'd0, (lat >= LAT_LO && lat <= LAT_HI)}, 32'd1);
        end
        chk({name, ":fe_count"}, mon_fe - b_fe, {31'd0, !stop_bit});
`ifdef UART_RX_PARITY_EN
        chk({name, ":pe_count"}, mon_pe - b_pe, {31'd0, stop_bit && par_flip});
`endif
        chk({name, ":rx_data"}, {24'd0, rx_data}, {24'd0, exp_data});
        chk({name, ":busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic       st;
        logic       pf;
        int         gap;

        rst = 1'b1;
        rx  = 1'b1;
        exp_data = 8'h00;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("reset:rx_data", {24'd0, rx_data}, 32'h00);
        chk("reset:rx_done", {31'd0, rx_done}, 32'd0);
        chk("reset:framing_error", {31'd0, framing_error}, 32'd0);
        chk("reset:busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        chk("a5:busy_before", {31'd0, busy}, 32'd0);
        frame("a5", 8'hA5, 1'b1, 1'b0);
        repeat (5) @(negedge clk);

        frame("b2b_00", 8'h00, 1'b1, 1'b0);
        frame("b2b_ff", 8'hFF, 1'b1, 1'b0);
        repeat (5) @(negedge clk);

        snap();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (15) @(negedge clk);
        chk("glitch:done_count", mon_done_data.size() - b_done, 32'd0);
        chk("glitch:fe_count", mon_fe - b_fe, 32'd0);
        chk("glitch:rx_data", {24'd0, rx_data}, {24'd0, exp_data});
        chk("glitch:busy", {31'd0, busy}, 32'd0);

        frame("good_3c", 8'h3C, 1'b1, 1'b0);
        frame("badstop_81", 8'h81, 1'b0, 1'b0);
        snap();
        repeat (30) @(negedge clk);
        chk("held_low:busy", {31'd0, busy}, 32'd0);
        chk("held_low:done_count", mon_done_data.size() - b_done, 32'd0);
        chk("held_low:fe_count", mon_fe - b_fe, 32'd0);
        chk("held_low:rx_data", {24'd0, rx_data}, 32'h3C);
        rx = 1'b1;
        repeat (5) @(negedge clk);

        snap();
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_data:busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_data = 8'h00;
        chk("mid_rst:rx_data", {24'd0, rx_data}, 32'h00);
        chk("mid_rst:rx_done", {31'd0, rx_done}, 32'd0);
        chk("mid_rst:framing_error", {31'd0, framing_error}, 32'd0);
        chk("mid_rst:busy", {31'd0, busy}, 32'd0);
        repeat (120) @(negedge clk);
        chk("mid_rst:no_done", mon_done_data.size() - b_done, 32'd0);
        chk("mid_rst:no_fe", mon_fe - b_fe, 32'd0);
        frame("after_rst_12", 8'h12, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
        frame("par_ok_07", 8'h07, 1'b1, 1'b0);
        frame("par_bad_07", 8'h07, 1'b1, 1'b1);
`endif

        for (int k = 0; k < 12; k++) begin
            d   = 8'($urandom);
            st  = ($urandom_range(0, 3) != 0);
            pf  = PAR_EN && ($urandom_range(0, 3) == 0);
            gap = st ? $urandom_range(0, 12) : $urandom_range(3, 12);
            frame($sformatf("rand%0d", k), d, st, pf);
            rx = 1'b1;
            repeat (gap) @(negedge clk);
        end
        repeat (5) @(negedge clk);

        chk("no_pulse_overlap", mon_overlap, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
